hwag_wheel_gen: RTL
===================

# hwag_wheel_gen

Crank/cam trigger-wheel generator: synthesises a 60-2 crank tooth signal and a once-per-720° cam signal from a programmable tooth period. It is the transmitting end of the crank/cam interface that the angle generator decodes. It drives the `cap`/`cam` inputs of the angle generator in simulation benches and on-board self-test, and runs as a stimulus source for bench rigs.

## Interface
- `TOOTH_TOTAL`, 60: tooth slots per crank revolution, including the missing slots.
- `TOOTH_MISSING`, 2: missing slots at the end of each revolution.
- `PERIOD_W`, 24: width of the period in clocks.
- `PERIOD_DEF`, 1000: period after reset.
- `PERIOD_MIN`, 4: lower clamp for the period.
- `CAM_START`, 10: first slot of the cam pulse.
- `CAM_LEN`, 5: length of the cam pulse, in slots.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: run request pulse.
- `stop` in 1: stop request pulse.
- `period_wr` in 1: period write strobe.
- `period_d` in PERIOD_W: new tooth period, in clocks.
- `cap` out 1: crank tooth signal.
- `cam` out 1: cam signal.
- `tooth` out 8: current slot index, 0..TOOTH_TOTAL-1.
- `rev` out 1: revolution half; 0 = first 360°, 1 = second.
- `gap_slot` out 1: current slot is a missing slot.
- `slot_strobe` out 1: one-cycle pulse on the first cycle of each slot.
- `busy` out 1: state ≠ IDLE.

## Operation
- State machine:
  - IDLE → RUN on `start`.
  - RUN → STOPPING on `stop`.
  - STOPPING → RUN on `start` without `stop`.
  - STOPPING → IDLE at the end of slot TOOTH_TOTAL-1 with `rev`=1 (720° boundary).
  - `start` & `stop` in the same cycle: `stop` wins. In IDLE that means stay IDLE.
- Registers:
  - `per`: active period.
  - `pend`: pending period.
  - `pend_v`: pending-valid flag.
  - `phase`: 0..per-1.
  - `tooth`, `rev`.
- `period_wr`: `pend` ← max(`period_d`, PERIOD_MIN) and `pend_v` ← 1. This is accepted in any state; a later write overwrites an earlier one.
- Slot boundary, when `phase` = per-1:
  - `phase` ← 0.
  - `tooth` ← tooth+1. At TOOTH_TOTAL-1 it wraps to 0 and `rev` toggles.
  - If `pend_v`: `per` ← `pend`, `pend_v` ← 0.
  - A write landing in the same cycle as a boundary is taken at the following boundary.
- Entering RUN from IDLE:
  - `phase` ← 0, `tooth` ← 0, `rev` ← 0.
  - `per` ← `pend` if `pend_v`, else `per` is kept.
- Waveform per slot, with h = per>>1:
  - Present tooth (tooth < TOOTH_TOTAL-TOOTH_MISSING): `cap`=1 for phase < h, 0 otherwise.
  - Missing slot: `cap`=0 for the whole slot and `gap_slot`=1.
  - The falling edge marks the tooth. Fall-to-fall spacing is `per`, except across the gap, where it is (TOOTH_MISSING+1)·per.
- `cam` = 1 iff `rev`=1 and CAM_START ≤ tooth < CAM_START+CAM_LEN.
- In IDLE:
  - `cap`, `cam`, `gap_slot`, `slot_strobe` are 0.
  - `tooth`, `rev`, `phase` hold 0.
- Reset mid-operation: everything returns to its reset value on the next edge, and a pending period is discarded.

## Timing
- Reset values:
  - `cap`, `cam`, `tooth`, `rev`, `gap_slot`, `slot_strobe`, `busy` = 0.
  - `per` = PERIOD_DEF; `pend_v` = 0.
- All outputs are registered and mutually consistent: in any cycle, `cap`/`cam`/`gap_slot` correspond to the `tooth`/`phase` shown in that cycle.
- `start` sampled at edge n:
  - `busy`=1, `slot_strobe`=1, `tooth`=0 and `cap`=1 all appear at edge n+1.
- Slot length is exactly `per` clocks. `slot_strobe` fires every `per` cycles.
- Stop completion: `busy` falls on the edge that would start slot 0 of `rev`=0. `cap` is already 0 there, so no runt pulse is generated.
- Width rules:
  - `phase` compare is PERIOD_W bits.
  - For odd `per`, `cap` high time is (per-1)/2 and low time is (per+1)/2.

## Structure
- Shared package `hwag_pkg` holds:
  - the state enum `wheel_state_t` (IDLE/RUN/STOPPING);
  - `TOOTH_TOTAL_DEF`=60 and `TOOTH_MISSING_DEF`=2, also used by the decoder;
  - `PERIOD_MIN_DEF`=4.
- One sub-module, `hwag_slot_timer`:
  - contents: the `phase` counter with synchronous clear, the `per`/`pend` double buffer and the terminal-count output;
  - the top level holds the FSM, the tooth/rev counters and the output decode.

## Test plan
- Reset, `period_wr` 8, `start` → `cap` is 4 high / 4 low per slot. Falling edges are 8 clocks apart for slots 0..57. The slot 57 → next slot 0 fall spacing is 24. `gap_slot`=1 for 16 clocks.
- Same run, cam → `cam` stays 0 through `rev`=0 and is high for exactly 40 clocks (slots 10..14) during `rev`=1. Pattern repeats every 960 clocks.
- Period 8 running, `period_wr` 20 at phase 3 of slot 5 → slot 5 lasts 8 clocks, slot 6 lasts 20 clocks. A write on a boundary cycle takes effect one slot later.
- `period_wr` 2, or 0 → `per`=4, with `cap` 2 high / 2 low.
- `stop` during `rev`=0, slot 30 → the run continues through `rev`=1 and `busy` drops at the 720° boundary with `cap`=0. `start`+`stop` in the same cycle in IDLE → remains IDLE.
- `rst` asserted mid-slot with pending period 50 → all outputs 0 next cycle and `per`=PERIOD_DEF. A subsequent `start` runs with 1000-clock slots.

Source files
------------

// File: rtl/hwag_pkg.sv
// rtl/hwag_pkg.sv - shared types and defaults for the crank/cam wheel blocks
package hwag_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } wheel_state_t;

  localparam int TOOTH_TOTAL_DEF   = 60;
  localparam int TOOTH_MISSING_DEF = 2;
  localparam int PERIOD_MIN_DEF    = 4;

endpackage

// File: rtl/hwag_wheel_gen_if.sv
// rtl/hwag_wheel_gen_if.sv - control and wheel-output bundle of the trigger-wheel generator
interface hwag_wheel_gen_if #(
  parameter int PERIOD_W = 24
) ();

  logic                start;
  logic                stop;
  logic                period_wr;
  logic [PERIOD_W-1:0] period_d;
  logic                cap;
  logic                cam;
  logic [7:0]          tooth;
  logic                rev;
  logic                gap_slot;
  logic                slot_strobe;
  logic                busy;

  modport master (
    output start, stop, period_wr, period_d,
    input  cap, cam, tooth, rev, gap_slot, slot_strobe, busy
  );

  modport slave (
    input  start, stop, period_wr, period_d,
    output cap, cam, tooth, rev, gap_slot, slot_strobe, busy
  );

endinterface

// File: rtl/hwag_slot_timer.sv
// rtl/hwag_slot_timer.sv - slot phase counter with double-buffered period
// Exposes next-cycle phase/period so the top can register its decoded outputs.
module hwag_slot_timer #(
  parameter int PERIOD_W   = 24,
  parameter int PERIOD_DEF = 1000,
  parameter int PERIOD_MIN = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en_i,
  input  logic                load_i,
  input  logic                wr_i,
  input  logic [PERIOD_W-1:0] wr_per_i,
  output logic                tc_o,
  output logic [PERIOD_W-1:0] phase_nxt_o,
  output logic [PERIOD_W-1:0] per_nxt_o
);

  localparam logic [PERIOD_W-1:0] PER_DEF = PERIOD_W'(PERIOD_DEF);
  localparam logic [PERIOD_W-1:0] PER_MIN = PERIOD_W'(PERIOD_MIN);
  localparam logic [PERIOD_W-1:0] ONE     = PERIOD_W'(1);

  logic [PERIOD_W-1:0] phase_q, phase_d;
  logic [PERIOD_W-1:0] per_q, per_d;
  logic [PERIOD_W-1:0] pend_q, pend_d;
  logic                pend_v_q, pend_v_d;

  assign tc_o = en_i && (phase_q == per_q - ONE);

  always_comb begin
    phase_d  = phase_q + ONE;
    per_d    = per_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    if (!en_i || tc_o) begin
      phase_d = '0;
    end
    // The boundary consumes the old pending value, so a write on the same edge waits a slot.
    if ((tc_o || load_i) && pend_v_q) begin
      per_d    = pend_q;
      pend_v_d = 1'b0;
    end
    if (wr_i) begin
      pend_d   = (wr_per_i < PER_MIN) ? PER_MIN : wr_per_i;
      pend_v_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q  <= '0;
      per_q    <= PER_DEF;
      pend_q   <= PER_DEF;
      pend_v_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      per_q    <= per_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
    end
  end

  assign phase_nxt_o = phase_d;
  assign per_nxt_o   = per_d;

endmodule

// File: rtl/hwag_wheel_gen.sv
// rtl/hwag_wheel_gen.sv - 60-2 crank / once-per-720 cam trigger-wheel generator
// Holds the run FSM, tooth/rev counters and the registered waveform decode.
module hwag_wheel_gen
  import hwag_pkg::*;
#(
  parameter int TOOTH_TOTAL   = TOOTH_TOTAL_DEF,
  parameter int TOOTH_MISSING = TOOTH_MISSING_DEF,
  parameter int PERIOD_W      = 24,
  parameter int PERIOD_DEF    = 1000,
  parameter int PERIOD_MIN    = PERIOD_MIN_DEF,
  parameter int CAM_START     = 10,
  parameter int CAM_LEN       = 5
) (
  input logic             clk,
  input logic             rst,
  hwag_wheel_gen_if.slave bus
);

  localparam logic [7:0] LAST_SLOT = 8'(TOOTH_TOTAL - 1);
  localparam logic [7:0] FIRST_GAP = 8'(TOOTH_TOTAL - TOOTH_MISSING);
  localparam logic [7:0] CAM_LO    = 8'(CAM_START);
  localparam logic [7:0] CAM_HI    = 8'(CAM_START + CAM_LEN);

  wheel_state_t        state_q, state_d;
  logic                load;
  logic                tc;
  logic [PERIOD_W-1:0] phase_nxt, per_nxt;
  logic [7:0]          tooth_q, tooth_d;
  logic                rev_q, rev_d;
  logic                active_d;
  logic                cap_q, cap_d;
  logic                cam_q, cam_d;
  logic                gap_q, gap_d;
  logic                strobe_q, strobe_d;
  logic                busy_q;

  hwag_slot_timer #(
    .PERIOD_W   (PERIOD_W),
    .PERIOD_DEF (PERIOD_DEF),
    .PERIOD_MIN (PERIOD_MIN)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .en_i        (state_q != IDLE),
    .load_i      (load),
    .wr_i        (bus.period_wr),
    .wr_per_i    (bus.period_d),
    .tc_o        (tc),
    .phase_nxt_o (phase_nxt),
    .per_nxt_o   (per_nxt)
  );

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start && !bus.stop) begin
          state_d = RUN;
          load    = 1'b1;
        end
      end
      RUN: begin
        if (bus.stop) state_d = STOPPING;
      end
      STOPPING: begin
        if (bus.start && !bus.stop) begin
          state_d = RUN;
        end else if (tc && (tooth_q == LAST_SLOT) && rev_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tooth_d = tooth_q;
    rev_d   = rev_q;
    if (state_d == IDLE) begin
      tooth_d = '0;
      rev_d   = 1'b0;
    end else if (tc) begin
      if (tooth_q == LAST_SLOT) begin
        tooth_d = '0;
        rev_d   = ~rev_q;
      end else begin
        tooth_d = tooth_q + 8'd1;
      end
    end
  end

  // Decode from next-cycle values so every output lines up with the tooth/phase it shows.
  always_comb begin
    active_d = (state_d != IDLE);
    cap_d    = active_d && (tooth_d < FIRST_GAP) && (phase_nxt < (per_nxt >> 1));
    gap_d    = active_d && (tooth_d >= FIRST_GAP);
    cam_d    = active_d && rev_d && (tooth_d >= CAM_LO) && (tooth_d < CAM_HI);
    strobe_d = active_d && (phase_nxt == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      tooth_q  <= '0;
      rev_q    <= 1'b0;
      cap_q    <= 1'b0;
      cam_q    <= 1'b0;
      gap_q    <= 1'b0;
      strobe_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tooth_q  <= tooth_d;
      rev_q    <= rev_d;
      cap_q    <= cap_d;
      cam_q    <= cam_d;
      gap_q    <= gap_d;
      strobe_q <= strobe_d;
      busy_q   <= active_d;
    end
  end

  assign bus.cap         = cap_q;
  assign bus.cam         = cam_q;
  assign bus.tooth       = tooth_q;
  assign bus.rev         = rev_q;
  assign bus.gap_slot    = gap_q;
  assign bus.slot_strobe = strobe_q;
  assign bus.busy        = busy_q;

endmodule
